uart_cmd_rx: RTL

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/uart_cmd_rx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// UART receiver assembling four bytes MSB-first into a 32-bit command word.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity); default is 8N1.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RXD,
  output logic [31:0] cmd_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          rxd_meta_q;
  logic          rxd_q;
  state_t        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [1:0]    byte_cnt_q;
  logic [23:0]   asm_q;
  logic [31:0]   new_word_q;
  logic          word_done_q;
  logic          frame_err_q;
  logic [TW-1:0] idle_cnt_q;
  logic [31:0]   cmd_word_q;
  logic          cmd_valid_q;
  logic          overrun_q;

  logic rxd;
  logic bit_tick;
  logic stop_ok;
  logic timeout_hit;
  logic accept;

  assign rxd = rxd_q;
  assign bit_tick = (clk_cnt_q == BIT_LAST);
  assign timeout_hit = (idle_cnt_q == TO_LAST);
  assign accept = cmd_valid_q & cmd_ready;

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign stop_ok = rxd & ~par_err_q;
`else
  assign stop_ok = rxd;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q <= 1'b1;
      rxd_q      <= 1'b1;
    end else begin
      rxd_meta_q <= RXD;
      rxd_q      <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      new_word_q  <= '0;
      word_done_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      word_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          clk_cnt_q <= '0;
          if (timeout_hit) byte_cnt_q <= '0;
          if (!rxd) begin
            state_q   <= S_START;
            bit_cnt_q <= '0;
          end
        end
        S_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= rxd ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            shift_q   <= {rxd, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            // even parity: the data ones plus this bit must be even
            par_err_q <= rxd ^ (^shift_q);
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            if (stop_ok) begin
              state_q    <= S_IDLE;
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                word_done_q <= 1'b1;
                new_word_q  <= {asm_q, shift_q};
              end else begin
                asm_q <= {asm_q[15:0], shift_q};
              end
            end else begin
              state_q     <= S_WAIT_HIGH;
              frame_err_q <= 1'b1;
              byte_cnt_q  <= '0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        S_WAIT_HIGH: begin
          clk_cnt_q <= '0;
          if (rxd) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // counts idle time only while a partial word is pending; saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_q <= '0;
    end else if (state_q != S_IDLE || byte_cnt_q == 2'd0) begin
      idle_cnt_q <= '0;
    end else if (!timeout_hit) begin
      idle_cnt_q <= idle_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_word_q  <= '0;
      cmd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (word_done_q) begin
        if (!cmd_valid_q || accept) begin
          cmd_word_q  <= new_word_q;
          cmd_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (accept) begin
        cmd_valid_q <= 1'b0;
      end
    end
  end

  assign cmd_word  = cmd_word_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
